// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: NPC select codes, IFU states
// and the reset PC default.
package ifu_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JUMPR  = 2'b11
   } npc_op_e;

   typedef enum logic [2:0] {
      IFU_IDLE = 3'd0,
      IFU_REQ  = 3'd1,
      IFU_WAIT = 3'd2,
      IFU_HOLD = 3'd3,
      IFU_HALT = 3'd4
   } ifu_state_e;

   // Sign-extended, word-scaled branch displacement.
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the instruction held at decode: sequential, PC-relative
// branch, region jump or register target.
module npc_calc
   import ifu_fetch_pkg::*;
(
   input  logic [31:0] instr_pc,
   input  logic [25:0] instr_idx,
   input  logic [1:0]  npc_op,
   input  logic [31:0] rs_val,
   output logic [31:0] npc
);

   logic [31:0] pc4;

   always_comb begin
      pc4 = instr_pc + 32'd4;
      npc = pc4;
      case (npc_op_e'(npc_op))
         NPC_PLUS4:  npc = pc4;
         NPC_BRANCH: npc = pc4 + br_offset(instr_idx[15:0]);
         NPC_JUMP:   npc = {pc4[31:28], instr_idx, 2'b00};
         NPC_JUMPR:  npc = rs_val;
         default:    npc = pc4;
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, req/gnt/rvalid fetch FSM, single-entry
// instruction hold for decode, memory watchdog and retire counter.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rstn,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic [31:0]      instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic [1:0]       npc_op,
   input  logic [31:0]      rs_val,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   ifu_state_e      state, state_nxt;
   logic [31:0]     pc;
   logic [31:0]     npc;
   logic [WD_W-1:0] wd;
   logic            wd_expired;
   logic            misalign;

   npc_calc u_npc_calc (
      .instr_pc  (instr_pc),
      .instr_idx (instr[25:0]),
      .npc_op    (npc_op),
      .rs_val    (rs_val),
      .npc       (npc)
   );

   // The check happens before the increment, so the error edge lands exactly
   // TIMEOUT cycles after the grant edge.
   always_comb begin
      wd_expired = (wd == WD_W'(TIMEOUT - 1));
      misalign   = (npc[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IFU_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      imem_addr   = pc;
      case (state)
         IFU_IDLE: state_nxt = IFU_REQ;
         IFU_REQ: begin
            imem_req = 1'b1;
            if (imem_gnt) state_nxt = IFU_WAIT;
         end
         IFU_WAIT: begin
            if (imem_rvalid)     state_nxt = IFU_HOLD;
            else if (wd_expired) state_nxt = IFU_HALT;
         end
         IFU_HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) state_nxt = misalign ? IFU_HALT : IFU_REQ;
         end
         IFU_HALT: state_nxt = IFU_HALT;
         default:  state_nxt = IFU_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc         <= RESET_PC;
         instr      <= '0;
         instr_pc   <= '0;
         fetch_err  <= 1'b0;
         retire_cnt <= '0;
         wd         <= '0;
      end else begin
         case (state)
            IFU_REQ: begin
               if (imem_gnt) wd <= '0;
            end
            IFU_WAIT: begin
               if (imem_rvalid) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc;
               end else if (wd_expired) begin
                  fetch_err <= 1'b1;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            IFU_HOLD: begin
               // A misaligned target still retires the instruction but leaves pc alone.
               if (instr_ready) begin
                  retire_cnt <= retire_cnt + CNT_W'(1);
                  if (misalign) fetch_err <= 1'b1;
                  else          pc        <= npc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: transaction-level model updated by the stimulus
// tasks, a per-cycle compare process, and literal spot checks.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  npc_op;
   logic [31:0] rs_val;
   logic        fetch_err;
   logic [31:0] retire_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_instr, m_ipc, m_ret;
   logic        m_err, m_req, m_valid;
   bit          chk_en = 1'b0;

   localparam int unsigned TO = 16;

   ifu_fetch #(
      .RESET_PC (32'h0000_3000),
      .TIMEOUT  (TO),
      .CNT_W    (32)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .npc_op      (npc_op),
      .rs_val      (rs_val),
      .fetch_err   (fetch_err),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_npc(input logic [31:0] ipc, input logic [31:0] ins,
                                             input logic [1:0] op, input logic [31:0] rs);
      logic [31:0] seq, imm;
      seq = ipc + 32'd4;
      imm = ins & 32'h0000_FFFF;
      if (ins[15]) imm = imm | 32'hFFFF_0000;
      case (op)
         2'd0:    return seq;
         2'd1:    return seq + (imm << 2);
         2'd2:    return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
         default: return rs;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check32("imem_req", 32'(imem_req), 32'(m_req));
         if (m_req) check32("imem_addr", imem_addr, m_pc);
         check32("instr_valid", 32'(instr_valid), 32'(m_valid));
         if (m_valid) begin
            check32("instr", instr, m_instr);
            check32("instr_pc", instr_pc, m_ipc);
         end
         check32("retire_cnt", retire_cnt, m_ret);
         check32("fetch_err", 32'(fetch_err), 32'(m_err));
      end
   end

   task automatic drive_idle;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      instr_ready = 1'b0;
      npc_op      = 2'b11;
      rs_val      = 32'hBAD0_0001;
   endtask

   task automatic model_reset;
      m_pc    = 32'h0000_3000;
      m_instr = '0;
      m_ipc   = '0;
      m_ret   = '0;
      m_err   = 1'b0;
      m_req   = 1'b0;
      m_valid = 1'b0;
   endtask

   // Leaves the DUT one cycle into REQ, at posedge+1.
   task automatic do_reset;
      rstn = 1'b0;
      drive_idle();
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1 m_req = 1'b1;
   endtask

   task automatic fetch(input int unsigned gnt_dly, input int unsigned rv_dly,
                        input logic [31:0] data, input bit early_rv);
      repeat (gnt_dly) begin @(posedge clk); #1; end
      imem_gnt = 1'b1;
      if (early_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hBADC_0DE5;
      end
      @(posedge clk); #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      m_req       = 1'b0;
      repeat (rv_dly) begin @(posedge clk); #1; end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      m_valid     = 1'b1;
      m_instr     = data;
      m_ipc       = m_pc;
   endtask

   task automatic accept(input logic [1:0] op, input logic [31:0] rs,
                         input int unsigned stall, input bit spurious);
      logic [31:0] nxt;
      repeat (stall) begin
         if (spurious) begin
            imem_rvalid = 1'b1;
            imem_gnt    = 1'b1;
            imem_rdata  = 32'h1234_5678;
         end
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      instr_ready = 1'b1;
      npc_op      = op;
      rs_val      = rs;
      nxt = model_npc(m_ipc, m_instr, op, rs);
      @(posedge clk); #1;
      drive_idle();
      m_valid = 1'b0;
      m_ret   = m_ret + 32'd1;
      if (nxt[1:0] != 2'b00) begin
         m_err = 1'b1;
         m_req = 1'b0;
      end else begin
         m_pc  = nxt;
         m_req = 1'b1;
      end
   endtask

   task automatic timeout_fetch(input int unsigned gnt_dly);
      repeat (gnt_dly) begin @(posedge clk); #1; end
      imem_gnt = 1'b1;
      @(posedge clk); #1;
      imem_gnt = 1'b0;
      m_req    = 1'b0;
      repeat (TO - 1) begin @(posedge clk); #1; end
      check32("t4_err_before_timeout", 32'(fetch_err), 32'd0);
      @(posedge clk); #1;
      m_err = 1'b1;
      check32("t4_err_at_timeout", 32'(fetch_err), 32'd1);
   endtask

   // Bus and decoder activity while halted must change nothing.
   task automatic halt_hold(input int unsigned n);
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h5555_AAAA;
      instr_ready = 1'b1;
      npc_op      = 2'b00;
      repeat (n) begin @(posedge clk); #1; end
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset, immediate grant, data next cycle, sequential accept
      do_reset();
      check32("t1_first_addr", imem_addr, 32'h0000_3000);
      fetch(0, 0, 32'h2008_0005, 1'b0);
      check32("t1_instr_pc", instr_pc, 32'h0000_3000);
      check32("t1_instr", instr, 32'h2008_0005);
      accept(2'b00, 32'h0, 0, 1'b0);
      check32("t1_next_addr", imem_addr, 32'h0000_3004);
      check32("t1_retire", retire_cnt, 32'd1);

      // Register jump to 0x3010, then branches backward and forward
      fetch(2, 0, 32'h0000_0000, 1'b1);
      accept(2'b11, 32'h0000_3010, 0, 1'b0);
      fetch(0, 3, 32'h1000_FFFE, 1'b0);
      check32("t2_instr_pc", instr_pc, 32'h0000_3010);
      accept(2'b01, 32'h0, 0, 1'b0);
      check32("t2_branch_back", imem_addr, 32'h0000_300C);

      // Long decode stall with spurious bus strobes, then one retire
      fetch(0, 0, 32'h0000_0000, 1'b0);
      accept(2'b00, 32'h0, 10, 1'b1);
      check32("t5_single_retire", retire_cnt, 32'd4);

      fetch(0, 0, 32'h1000_0003, 1'b0);
      accept(2'b01, 32'h0, 0, 1'b0);
      check32("t2_branch_fwd", imem_addr, 32'h0000_3020);

      // Region jump from 0x3FFC, register jumps, misaligned target
      fetch(0, 0, 32'h0000_0000, 1'b0);
      accept(2'b11, 32'h0000_3FFC, 0, 1'b0);
      fetch(0, 0, 32'h0800_0C04, 1'b0);
      check32("t3_instr_pc", instr_pc, 32'h0000_3FFC);
      accept(2'b10, 32'h0, 0, 1'b0);
      check32("t3_jump", imem_addr, 32'h0000_3010);
      fetch(1, 1, 32'h0000_0000, 1'b0);
      accept(2'b11, 32'h0000_4000, 0, 1'b0);
      check32("t3_jr", imem_addr, 32'h0000_4000);
      fetch(0, 0, 32'h0000_0000, 1'b0);
      accept(2'b11, 32'h0000_4002, 0, 1'b0);
      check32("t3_misalign_err", 32'(fetch_err), 32'd1);
      check32("t3_halt_no_req", 32'(imem_req), 32'd0);
      check32("t3_retire", retire_cnt, 32'd9);
      halt_hold(4);

      // Delayed grant then memory timeout
      do_reset();
      timeout_fetch(5);
      halt_hold(3);
      check32("t4_halt_frozen_retire", retire_cnt, 32'd0);

      // Asynchronous reset during WAIT, late rvalid after release
      do_reset();
      fetch(0, 0, 32'hCAFE_0001, 1'b0);
      accept(2'b00, 32'h0, 0, 1'b0);
      imem_gnt = 1'b1;
      @(posedge clk); #1;
      imem_gnt = 1'b0;
      m_req    = 1'b0;
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check32("t6_req_async", 32'(imem_req), 32'd0);
      check32("t6_valid_async", 32'(instr_valid), 32'd0);
      check32("t6_instr_async", instr, 32'h0);
      check32("t6_instr_pc_async", instr_pc, 32'h0);
      check32("t6_retire_async", retire_cnt, 32'd0);
      check32("t6_pc_async", imem_addr, 32'h0000_3000);
      @(posedge clk); #1;
      rstn        = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0BAD_F00D;
      @(posedge clk); #1;
      m_req = 1'b1;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      check32("t6_first_addr", imem_addr, 32'h0000_3000);
      fetch(0, 0, 32'h2008_0005, 1'b0);
      accept(2'b00, 32'h0, 0, 1'b0);
      check32("t6_next_addr", imem_addr, 32'h0000_3004);
      check32("t6_retire", retire_cnt, 32'd1);

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
